encoder: RTL and testbench
==========================

// Module: encoder
// PURPOSE
//  Transmit-side counterpart of the chained-shift 3-bit cipher. Takes an N-bit word as N/3 3-bit elements and encodes them
//  most-significant element first: enc[top] = (plain[top] + 1) mod 8, enc[k] = (plain[k] + enc[k+1]) mod 8.
//  Output pairs with the decoder: its mod=0 parallel input, or its mod=1 serial input via the optional serial stream.
// PARAMETERS
//  N  30  word width in bits; multiple of 3, 3 <= N <= 96 (element index fits 5 bits)
// PORTS
//  clk         in   1    single clock, rising edge
//  rst         in   1    synchronous, active-high reset
//  basla       in   1    start strobe; sampled only in BOS
//  mod         in   1    0: parallel load of gelen_veri; 1: serial load, one element/cycle on gelen_veri[2:0]
//  gelen_veri  in   N    plain data (element i = bits [3i+2:3i])
//  cikan_veri  out  N    encoded word; valid when bitti=1, held until overwritten by next run
//  bitti       out  1    one-cycle done pulse
//  seri_basla  out  1    first-element strobe of serial stream (feeds decoder basla)
//  seri_veri   out  3    serial encoded element, MSB element first
// BEHAVIOUR
//  Reset: cikan_veri=0, bitti=0, seri_basla=0, seri_veri=0, raw buffer=0, state=BOS, counter=N/3-1, shift=1.
//  FSM: BOS (idle) -> AL (serial load) -> SIFRELE (encode) -> BOS.
//  BOS: basla&~mod: latch all N/3 elements in one edge, counter=N/3-1, shift=1 -> SIFRELE.
//       basla&mod: latch gelen_veri[2:0] as element N/3-1, counter=N/3-2 -> AL (N=3: -> SIFRELE directly).
//  AL: every edge store gelen_veri[2:0] to element[counter], counter-1; basla/mod ignored; counter==0 -> SIFRELE, counter=N/3-1.
//  SIFRELE: per edge e = (raw[counter] + shift) mod 8 (3-bit wrap, no carry kept); cikan_veri[3*counter+:3] <= e;
//       shift <= e; counter-1; at counter==0: bitti <= 1, counter=N/3-1, shift=1 -> BOS.
//  Latency (basla sampled at edge 0): mod=0 bitti high after edge N/3; mod=1 after edge 2N/3-1. Exactly one cycle.
//  cikan_veri updated element-wise during SIFRELE; only the value at bitti is defined.
//  basla while busy (AL/SIFRELE) ignored, no queuing. basla in the cycle bitti is high is accepted (state already BOS).
//  rst mid-operation aborts: all reset values restored next edge, no bitti for the aborted run.
//  mod is sampled only with basla in BOS; changes mid-run have no effect.
// CONFIGURATION
//  SERI_CIKIS_EN defined: each element encoded in SIFRELE is also registered on seri_veri in the same edge;
//    seri_basla=1 together with the first (element N/3-1) only; the N/3 elements appear on N/3 consecutive cycles, the last one
//    coinciding with bitti. Matches the decoder mod=1 protocol (basla with first element, rest unconditional).
//  SERI_CIKIS_EN undefined: seri_basla and seri_veri tied to 0; no serial registers; all other timing identical.
// STRUCTURE
//  Shared package: ELEMAN_W=3, BASLANGIC_KAYDIRMA=3'd1, state encoding (BOS/AL/SIFRELE), function
//    eleman_sifrele(raw,shift) returning 3-bit mod-8 sum; decoder uses the same constants.
//  No sub-module: single FSM + datapath; raw buffer as N/3 x 3-bit array; next-state/registered split.
// TESTING (N=30)
//  mod=0, gelen_veri=0, basla 1 cycle -> bitti after edge 10, cikan_veri=30'h09249249 (all elements 3'b001).
//  mod=0, gelen_veri=30'h3FFFFFFF -> cikan_veri=30'h07D63447 (elements 0,7,6,5,4,3,2,1,0,7 MSB first; wrap check).
//  mod=1, elements streamed 7 then nine 0s on gelen_veri[2:0] -> bitti after edge 19, cikan_veri = elements 0,0,...,0
//    (top (7+1) mod 8=0, then 0+0): 30'h00000000; bitti exactly one cycle.
//  basla pulsed repeatedly during SIFRELE, then rst asserted mid-AL -> no extra run, no bitti, outputs 0, next run correct.
//  SERI_CIKIS_EN: serial output wired to decoder (basla=seri_basla, mod=1, gelen_veri[2:0]=seri_veri), 200 random words ->
//    decoder cikan_veri equals original plain word each run; seri_basla high exactly once per run.
//  Back-to-back: basla in the bitti cycle -> second run starts, second bitti after edge 10 of that run.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared constants and types for the chained-shift 3-bit cipher.
// Used by the encoder and by its paired decoder.
package encoder_pkg;

    localparam int ELEMAN_W = 3;
    localparam logic [2:0] BASLANGIC_KAYDIRMA = 3'd1;

    typedef enum logic [1:0] {
        BOS     = 2'd0,
        AL      = 2'd1,
        SIFRELE = 2'd2
    } durum_t;

    // One element of the chain: 3-bit sum, wraps mod 8, no carry out.
    function automatic logic [2:0] eleman_sifrele(
        input logic [2:0] ham,
        input logic [2:0] kaydirma
    );
        return ham + kaydirma;
    endfunction

endpackage

// File: rtl/encoder_if.sv
// Data/handshake bundle of the encoder.
// master: plain data source and result sink; slave: encoder.
interface encoder_if #(
    parameter int N = 30
);
    logic         basla;
    logic         mod;
    logic [N-1:0] gelen_veri;
    logic [N-1:0] cikan_veri;
    logic         bitti;
    logic         seri_basla;
    logic [2:0]   seri_veri;

    modport master (
        output basla, mod, gelen_veri,
        input  cikan_veri, bitti, seri_basla, seri_veri
    );

    modport slave (
        input  basla, mod, gelen_veri,
        output cikan_veri, bitti, seri_basla, seri_veri
    );
endinterface

// File: rtl/encoder.sv
// Chained-shift 3-bit cipher encoder, MSB element first.
// Ports: clk, rst (sync, active-high), bus (encoder_if.slave):
//   basla/mod/gelen_veri in; cikan_veri/bitti/seri_basla/seri_veri out.
// Option: SERI_CIKIS_EN enables the serial output stream.
module encoder
    import encoder_pkg::*;
#(
    parameter int N = 30
) (
    input logic      clk,
    input logic      rst,
    encoder_if.slave bus
);

    localparam int M = N / ELEMAN_W;
    localparam logic [4:0] SON = 5'(M - 1);

    durum_t       durum;
    logic [4:0]   sayac;
    logic [2:0]   kaydirma;
    logic [2:0]   ham [M];
    logic [N-1:0] cikan_r;
    logic         bitti_r;
    logic [2:0]   ham_sec;
    logic [2:0]   e;

    // Element select by counter; explicit compare avoids index width issues.
    always_comb begin
        ham_sec = '0;
        for (int i = 0; i < M; i++) begin
            if (sayac == 5'(i)) ham_sec = ham[i];
        end
    end

    assign e = eleman_sifrele(ham_sec, kaydirma);

`ifdef SERI_CIKIS_EN
    logic       seri_basla_r;
    logic [2:0] seri_veri_r;
    assign bus.seri_basla = seri_basla_r;
    assign bus.seri_veri  = seri_veri_r;
`else
    assign bus.seri_basla = 1'b0;
    assign bus.seri_veri  = 3'd0;
`endif

    assign bus.cikan_veri = cikan_r;
    assign bus.bitti      = bitti_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            durum    <= BOS;
            sayac    <= SON;
            kaydirma <= BASLANGIC_KAYDIRMA;
            cikan_r  <= '0;
            bitti_r  <= 1'b0;
            for (int i = 0; i < M; i++) ham[i] <= '0;
`ifdef SERI_CIKIS_EN
            seri_basla_r <= 1'b0;
            seri_veri_r  <= 3'd0;
`endif
        end else begin
            bitti_r <= 1'b0;
`ifdef SERI_CIKIS_EN
            seri_basla_r <= 1'b0;
`endif
            unique case (durum)
                BOS: begin
                    if (bus.basla) begin
                        if (!bus.mod) begin
                            for (int i = 0; i < M; i++)
                                ham[i] <= bus.gelen_veri[ELEMAN_W*i +: ELEMAN_W];
                            sayac    <= SON;
                            kaydirma <= BASLANGIC_KAYDIRMA;
                            durum    <= SIFRELE;
                        end else begin
                            ham[M-1] <= bus.gelen_veri[2:0];
                            // A single-element word needs no further loading.
                            if (M == 1) begin
                                sayac <= SON;
                                durum <= SIFRELE;
                            end else begin
                                sayac <= SON - 5'd1;
                                durum <= AL;
                            end
                        end
                    end
                end
                AL: begin
                    for (int i = 0; i < M; i++) begin
                        if (sayac == 5'(i)) ham[i] <= bus.gelen_veri[2:0];
                    end
                    if (sayac == 5'd0) begin
                        sayac <= SON;
                        durum <= SIFRELE;
                    end else begin
                        sayac <= sayac - 5'd1;
                    end
                end
                SIFRELE: begin
                    for (int i = 0; i < M; i++) begin
                        if (sayac == 5'(i))
                            cikan_r[ELEMAN_W*i +: ELEMAN_W] <= e;
                    end
`ifdef SERI_CIKIS_EN
                    seri_veri_r  <= e;
                    seri_basla_r <= (sayac == SON);
`endif
                    if (sayac == 5'd0) begin
                        bitti_r  <= 1'b1;
                        sayac    <= SON;
                        kaydirma <= BASLANGIC_KAYDIRMA;
                        durum    <= BOS;
                    end else begin
                        kaydirma <= e;
                        sayac    <= sayac - 5'd1;
                    end
                end
                default: durum <= BOS;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder.sv
// Self-checking bench for encoder (N=30).
// Random words compared with a chain-sum reference model.
module tb_encoder;

    localparam int N = 30;
    localparam int M = N / 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    int          lat;
    logic [29:0] res;
    int          seri_cnt;
    logic [2:0]  seri_log [$];
    logic        seri_bad;

    encoder_if #(.N(N)) bus ();

    encoder #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] ref_enc(input logic [29:0] p);
        logic [29:0] r;
        int s;
        int v;
        r = '0;
        s = 1;
        for (int k = M - 1; k >= 0; k--) begin
            v = (int'(p[3*k +: 3]) + s) % 8;
            r[3*k +: 3] = 3'(v);
            s = v;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
`ifdef SERI_CIKIS_EN
        if (bus.seri_basla) seri_cnt++;
        seri_log.push_back(bus.seri_veri);
`else
        if (bus.seri_basla !== 1'b0 || bus.seri_veri !== 3'd0) seri_bad = 1'b1;
`endif
    endtask

    // Starts a run (basla in the current cycle), returns edges to bitti.
    task automatic run_word(input logic m, input logic [29:0] d);
        seri_cnt = 0;
        seri_log.delete();
        bus.basla = 1'b1;
        bus.mod = m;
        bus.gelen_veri = m ? {$urandom(), $urandom()} : d;
        if (m) bus.gelen_veri[2:0] = d[29:27];
        tick();
        bus.basla = 1'b0;
        lat = 0;
        if (m) begin
            for (int k = M - 2; k >= 0; k--) begin
                bus.gelen_veri = {$urandom(), $urandom()};
                bus.gelen_veri[2:0] = d[3*k +: 3];
                tick();
                lat++;
            end
        end
        while (!bus.bitti && lat < 40) begin
            tick();
            lat++;
        end
        res = bus.cikan_veri;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.basla = 1'b0;
        bus.mod = 1'b0;
        bus.gelen_veri = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bus.cikan_veri !== 30'd0 || bus.bitti !== 1'b0) begin
            errors++;
            $display("FAIL reset: cikan=%h bitti=%b want 0/0", bus.cikan_veri, bus.bitti);
        end
        checks++;
        if (bus.seri_basla !== 1'b0 || bus.seri_veri !== 3'd0) begin
            errors++;
            $display("FAIL reset_seri: sb=%b sv=%h want 0/0", bus.seri_basla, bus.seri_veri);
        end
    endtask

    task automatic test_parallel_fixed();
        run_word(1'b0, 30'd0);
        checks++;
        if (lat != 10 || res !== 30'h09249249) begin
            errors++;
            $display("FAIL par_zero: lat=%0d res=%h want 10/09249249", lat, res);
        end
        tick();
        checks++;
        if (bus.bitti !== 1'b0) begin
            errors++;
            $display("FAIL bitti_pulse: bitti=%b want 0", bus.bitti);
        end
        run_word(1'b0, 30'h3FFFFFFF);
        checks++;
        if (lat != 10 || res !== 30'h07D63447) begin
            errors++;
            $display("FAIL par_ones: lat=%0d res=%h want 10/07D63447", lat, res);
        end
        tick();
    endtask

    task automatic test_serial_fixed();
        run_word(1'b1, 30'h38000000);
        checks++;
        if (lat != 19 || res !== 30'd0) begin
            errors++;
            $display("FAIL ser_wrap: lat=%0d res=%h want 19/0", lat, res);
        end
        tick();
        checks++;
        if (bus.bitti !== 1'b0) begin
            errors++;
            $display("FAIL ser_pulse: bitti=%b want 0", bus.bitti);
        end
    endtask

    task automatic test_busy_abort();
        logic [29:0] w;
        logic [29:0] w2;
        int hits;
        w = 30'($urandom());
        bus.basla = 1'b1;
        bus.mod = 1'b0;
        bus.gelen_veri = w;
        tick();
        lat = 0;
        hits = 0;
        while (lat < 40) begin
            bus.basla = (lat < 9);
            bus.mod = lat[0];
            bus.gelen_veri = 30'($urandom());
            tick();
            lat++;
            if (bus.bitti) break;
        end
        bus.basla = 1'b0;
        checks++;
        if (lat != 10 || bus.cikan_veri !== ref_enc(w)) begin
            errors++;
            $display("FAIL busy: lat=%0d res=%h want 10/%h", lat, bus.cikan_veri, ref_enc(w));
        end
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.bitti) hits++;
        end
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL busy_extra: bitti_count=%0d want 0", hits);
        end
        bus.basla = 1'b1;
        bus.mod = 1'b1;
        bus.gelen_veri = 30'd5;
        tick();
        bus.basla = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.cikan_veri !== 30'd0 || bus.bitti !== 1'b0) begin
            errors++;
            $display("FAIL abort_rst: cikan=%h bitti=%b want 0/0", bus.cikan_veri, bus.bitti);
        end
        hits = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.bitti) hits++;
        end
        checks++;
        if (hits != 0 || bus.cikan_veri !== 30'd0) begin
            errors++;
            $display("FAIL abort_quiet: bitti_count=%0d cikan=%h want 0/0", hits, bus.cikan_veri);
        end
        w2 = 30'($urandom());
        run_word(1'b1, w2);
        checks++;
        if (lat != 19 || res !== ref_enc(w2)) begin
            errors++;
            $display("FAIL after_abort: lat=%0d res=%h want 19/%h", lat, res, ref_enc(w2));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [29:0] a;
        logic [29:0] b;
        a = 30'($urandom());
        b = 30'($urandom());
        run_word(1'b0, a);
        checks++;
        if (lat != 10 || res !== ref_enc(a)) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d res=%h want 10/%h", lat, res, ref_enc(a));
        end
        run_word(1'b0, b);
        checks++;
        if (lat != 10 || res !== ref_enc(b)) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d res=%h want 10/%h", lat, res, ref_enc(b));
        end
        tick();
    endtask

    task automatic test_random();
        logic [29:0] w;
        logic [29:0] exp_w;
        logic        m;
        int          want;
        int          n;
        for (int r = 0; r < 60; r++) begin
            w = 30'($urandom());
            m = 1'($urandom_range(0, 1));
            exp_w = ref_enc(w);
            want = m ? 19 : 10;
            run_word(m, w);
            checks++;
            if (lat != want || res !== exp_w) begin
                errors++;
                $display("FAIL rand[%0d] mod=%b: lat=%0d res=%h want %0d/%h",
                         r, m, lat, res, want, exp_w);
            end
`ifdef SERI_CIKIS_EN
            n = seri_log.size();
            checks++;
            if (seri_cnt != 1 || n < M) begin
                errors++;
                $display("FAIL rand_seri_basla[%0d]: count=%0d want 1", r, seri_cnt);
            end else begin
                for (int k = 0; k < M; k++) begin
                    if (seri_log[n - M + k] !== exp_w[3*(M-1-k) +: 3]) begin
                        errors++;
                        $display("FAIL rand_seri[%0d] el=%0d: got %h want %h", r, k,
                                 seri_log[n - M + k], exp_w[3*(M-1-k) +: 3]);
                        break;
                    end
                end
            end
`else
            n = 0;
`endif
            if ($urandom_range(0, 2) == 0) tick();
        end
        checks++;
        if (seri_bad !== 1'b0) begin
            errors++;
            $display("FAIL seri_tied: nonzero serial output seen, want 0");
        end
    endtask

    initial begin
        seri_bad = 1'b0;
        seri_cnt = 0;
        test_reset();
        test_parallel_fixed();
        test_serial_fixed();
        test_busy_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
